// File: rtl/apb_gpio_irq.sv
// APB GPIO with SYNC_STAGES-deep input synchroniser and per-pin level/edge interrupts; GPIO_INT_BOTH_EDGE_EN adds INT_ANY at 0x20.
// Zero wait states (PREADY tied high); reads are combinational and writes commit on the access-phase edge.
module apb_gpio_irq #(
    parameter int GPIO_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  iPCLK,
    input  logic                  iPRESET,
    input  logic                  iPSEL,
    input  logic                  iPENABLE,
    input  logic                  iPWRITE,
    input  logic [31:0]           iPADDR,
    input  logic [31:0]           iPWDATA,
    output logic [31:0]           oPRDATA,
    output logic                  oPREADY,
    output logic                  oPSLVERR,
    input  logic [GPIO_WIDTH-1:0] iGPIOin,
    output logic [GPIO_WIDTH-1:0] oGPIOout,
    output logic [GPIO_WIDTH-1:0] oGPIOoe,
    output logic                  oIRQ
);
    localparam int W = GPIO_WIDTH;

    logic [W-1:0] data_q, data_d;
    logic [W-1:0] dirm_q, dirm_d;
    logic [W-1:0] oen_q, oen_d;
    logic [W-1:0] int_mask_q, int_mask_d;
    logic [W-1:0] int_type_q, int_type_d;
    logic [W-1:0] int_pol_q, int_pol_d;
    logic [W-1:0] int_stat_q, int_stat_d;
    logic [W-1:0] prev_q, prev_d;
    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] sync_d [SYNC_STAGES];
    logic [W-1:0] int_any;
`ifdef GPIO_INT_BOTH_EDGE_EN
    logic [W-1:0] int_any_q, int_any_d;
    assign int_any = int_any_q;
`else
    assign int_any = '0;
`endif

    logic [3:0]   reg_idx;
    logic         aligned;
    logic         mapped;
    logic         access;
    logic         bus_err;
    logic         wr_en;
    logic [W-1:0] wdat;
    logic [W-1:0] sync_in;
    logic [W-1:0] pol_match;
    logic [W-1:0] edge_hit;
    logic [W-1:0] int_set;
    logic [W-1:0] int_clr;
    logic [W-1:0] rd_val;

    logic unused_paddr;
    assign unused_paddr = ^iPADDR[31:6];
    generate
        if (W < 32) begin : g_unused_wdata
            logic unused_wdata;
            assign unused_wdata = ^iPWDATA[31:W];
        end
    endgenerate

    assign reg_idx = iPADDR[5:2];
    assign aligned = (iPADDR[1:0] == 2'b00);
`ifdef GPIO_INT_BOTH_EDGE_EN
    assign mapped  = aligned && (reg_idx <= 4'd8);
`else
    assign mapped  = aligned && (reg_idx <= 4'd7);
`endif
    assign access   = iPSEL & iPENABLE;
    // DATA_RO is read-only, so a write there is an error just like an unmapped offset
    assign bus_err  = access & (~mapped | (iPWRITE & (reg_idx == 4'd0)));
    assign wr_en    = access & iPWRITE & ~bus_err;
    assign wdat     = iPWDATA[W-1:0];
    assign oPSLVERR = bus_err;
    assign oPREADY  = 1'b1;

    always_comb begin
        sync_d[0] = iGPIOin;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end
    assign sync_in = sync_q[SYNC_STAGES-1];
    assign prev_d  = sync_in;

    // Only input pins detect; INT_ANY turns an edge pin into a both-edge detector
    assign pol_match = ~(sync_in ^ int_pol_q);
    assign edge_hit  = (sync_in ^ prev_q) & (pol_match | int_any);
    assign int_set   = ~dirm_q & ((int_type_q & edge_hit) | (~int_type_q & pol_match));

    always_comb begin
        data_d     = data_q;
        dirm_d     = dirm_q;
        oen_d      = oen_q;
        int_mask_d = int_mask_q;
        int_type_d = int_type_q;
        int_pol_d  = int_pol_q;
`ifdef GPIO_INT_BOTH_EDGE_EN
        int_any_d  = int_any_q;
`endif
        int_clr    = '0;
        if (wr_en) begin
            case (reg_idx)
                4'd1: data_d     = wdat;
                4'd2: dirm_d     = wdat;
                4'd3: oen_d      = wdat;
                4'd4: int_mask_d = wdat;
                4'd5: int_type_d = wdat;
                4'd6: int_pol_d  = wdat;
                4'd7: int_clr    = wdat;
`ifdef GPIO_INT_BOTH_EDGE_EN
                4'd8: int_any_d  = wdat;
`endif
                default: ;
            endcase
        end
        // A set in the same cycle as a W1C wins
        int_stat_d = (int_stat_q & ~int_clr) | int_set;
    end

    always_comb begin
        rd_val = '0;
        case (reg_idx)
            4'd0: rd_val = (dirm_q & data_q) | (~dirm_q & sync_in);
            4'd1: rd_val = data_q;
            4'd2: rd_val = dirm_q;
            4'd3: rd_val = oen_q;
            4'd4: rd_val = int_mask_q;
            4'd5: rd_val = int_type_q;
            4'd6: rd_val = int_pol_q;
            4'd7: rd_val = int_stat_q;
            4'd8: rd_val = int_any;
            default: rd_val = '0;
        endcase
        oPRDATA = '0;
        if (iPSEL && mapped) begin
            oPRDATA[W-1:0] = rd_val;
        end
    end

    always_ff @(posedge iPCLK or posedge iPRESET) begin
        if (iPRESET) begin
            data_q     <= '0;
            dirm_q     <= '0;
            oen_q      <= '0;
            int_mask_q <= '0;
            int_type_q <= '0;
            int_pol_q  <= '0;
            int_stat_q <= '0;
            prev_q     <= '0;
`ifdef GPIO_INT_BOTH_EDGE_EN
            int_any_q  <= '0;
`endif
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            data_q     <= data_d;
            dirm_q     <= dirm_d;
            oen_q      <= oen_d;
            int_mask_q <= int_mask_d;
            int_type_q <= int_type_d;
            int_pol_q  <= int_pol_d;
            int_stat_q <= int_stat_d;
            prev_q     <= prev_d;
`ifdef GPIO_INT_BOTH_EDGE_EN
            int_any_q  <= int_any_d;
`endif
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    assign oGPIOout = data_q;
    assign oGPIOoe  = dirm_q & oen_q;
    assign oIRQ     = |(int_stat_q & int_mask_q);
endmodule

// File: tb/tb_apb_gpio_irq.sv
// Randomised bench for apb_gpio_irq (8 pins, 2-stage synchroniser) against a register-level reference model.
module tb_apb_gpio_irq;
    localparam int W  = 8;
    localparam int SS = 2;
`ifdef GPIO_INT_BOTH_EDGE_EN
    localparam bit ANY = 1'b1;
`else
    localparam bit ANY = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          psel, penable, pwrite;
    logic [31:0]   paddr, pwdata;
    logic [31:0]   prdata;
    logic          pready, pslverr;
    logic [W-1:0]  gpio_in, gpio_out, gpio_oe;
    logic          irq;

    apb_gpio_irq #(.GPIO_WIDTH(W), .SYNC_STAGES(SS)) dut (
        .iPCLK(clk), .iPRESET(rst), .iPSEL(psel), .iPENABLE(penable), .iPWRITE(pwrite),
        .iPADDR(paddr), .iPWDATA(pwdata), .oPRDATA(prdata), .oPREADY(pready), .oPSLVERR(pslverr),
        .iGPIOin(gpio_in), .oGPIOout(gpio_out), .oGPIOoe(gpio_oe), .oIRQ(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_rd;
    logic        last_err;

    // Reference model: architectural registers plus the history of sampled pin values
    logic [W-1:0] m_data, m_dirm, m_oen, m_mask, m_type, m_pol, m_stat, m_any;
    logic [W-1:0] hist[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_data = '0; m_dirm = '0; m_oen = '0; m_mask = '0;
        m_type = '0; m_pol = '0; m_stat = '0; m_any = '0;
        hist = {};
        for (int i = 0; i <= SS; i++) hist.push_back('0);
    endtask

    // Synchronised value is the sample taken SS edges ago; prev is one sample older
    function automatic logic [W-1:0] m_sync();
        return hist[hist.size()-SS];
    endfunction
    function automatic logic [W-1:0] m_prev();
        return hist[hist.size()-SS-1];
    endfunction

    function automatic logic m_err(input logic [5:0] a, input logic wr);
        int idx;
        idx = int'(a[5:2]);
        if (a[1:0] != 2'b00) return 1'b1;
        if (idx > (ANY ? 8 : 7)) return 1'b1;
        return wr && (idx == 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] a);
        logic [W-1:0] v;
        v = '0;
        if (!m_err(a, 1'b0)) begin
            case (int'(a[5:2]))
                0: v = (m_dirm & m_data) | (~m_dirm & m_sync());
                1: v = m_data;
                2: v = m_dirm;
                3: v = m_oen;
                4: v = m_mask;
                5: v = m_type;
                6: v = m_pol;
                7: v = m_stat;
                8: v = m_any;
                default: v = '0;
            endcase
        end
        return {24'b0, v};
    endfunction

    task automatic tick();
        logic [W-1:0] si, pi, hit, clr, wd;
        logic [W-1:0] n_data, n_dirm, n_oen, n_mask, n_type, n_pol, n_any;
        si = m_sync();
        pi = m_prev();
        for (int i = 0; i < W; i++) begin
            hit[i] = 1'b0;
            if (!m_dirm[i]) begin
                if (m_type[i])
                    hit[i] = (si[i] != pi[i]) && ((si[i] == m_pol[i]) || m_any[i]);
                else
                    hit[i] = (si[i] == m_pol[i]);
            end
        end
        n_data = m_data; n_dirm = m_dirm; n_oen = m_oen; n_mask = m_mask;
        n_type = m_type; n_pol = m_pol; n_any = m_any; clr = '0;
        wd = pwdata[W-1:0];
        if (psel && penable && pwrite && !m_err(paddr[5:0], 1'b1)) begin
            case (int'(paddr[5:2]))
                1: n_data = wd;
                2: n_dirm = wd;
                3: n_oen  = wd;
                4: n_mask = wd;
                5: n_type = wd;
                6: n_pol  = wd;
                7: clr    = wd;
                8: n_any  = wd;
                default: ;
            endcase
        end
        @(posedge clk);
        m_stat = (m_stat & ~clr) | hit;
        m_data = n_data; m_dirm = n_dirm; m_oen = n_oen; m_mask = n_mask;
        m_type = n_type; m_pol = n_pol; m_any = n_any;
        hist.push_back(gpio_in);
        void'(hist.pop_front());
        #1;
        chk("gpio_out", {24'b0, gpio_out}, {24'b0, m_data});
        chk("gpio_oe", {24'b0, gpio_oe}, {24'b0, m_dirm & m_oen});
        chk("irq", {31'b0, irq}, {31'b0, |(m_stat & m_mask)});
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        tick();
        penable = 1'b1;
        #1;
        last_rd  = prdata;
        last_err = pslverr;
        chk("prdata", last_rd, m_read(a[5:0]));
        chk("pslverr", {31'b0, last_err}, {31'b0, m_err(a[5:0], wr)});
        chk("pready", {31'b0, pready}, 32'd1);
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        apb_xfer(1'b1, a, d);
    endtask

    task automatic apb_read(input logic [31:0] a);
        apb_xfer(1'b0, a, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int op;
        logic [31:0] a;
        gpio_in = '0;
        model_reset();
        do_reset();

        chk("rst_out", {24'b0, gpio_out}, 32'h0);
        chk("rst_oe", {24'b0, gpio_oe}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_slverr", {31'b0, pslverr}, 32'h0);
        chk("rst_pready", {31'b0, pready}, 32'h1);
        chk("rst_prdata", prdata, 32'h0);

        for (int i = 0; i <= 8; i++) apb_read(32'(i * 4));
        apb_read(32'h24);
        chk("unmapped_err", {31'b0, last_err}, 32'h1);
        apb_write(32'h00, 32'hFF);
        chk("ro_wr_err", {31'b0, last_err}, 32'h1);
        apb_read(32'h00);
        chk("ro_unchanged", last_rd, 32'h0);

        gpio_in = 8'h30;
        apb_write(32'h08, 32'hF0);
        apb_write(32'h0C, 32'h30);
        apb_write(32'h04, 32'hA5);
        chk("out_a5", {24'b0, gpio_out}, 32'hA5);
        chk("oe_30", {24'b0, gpio_oe}, 32'h30);
        apb_read(32'h00);
        chk("data_ro_hi", {28'b0, last_rd[7:4]}, 32'hA);

        apb_write(32'h04, 32'hFFFF_FFFF);
        apb_read(32'h04);
        chk("data_width", last_rd, 32'h0000_00FF);

        // Pin 0 rising edge, latency from the first sampling edge
        gpio_in = '0;
        apb_write(32'h08, 32'h0);
        apb_write(32'h14, 32'h01);
        apb_write(32'h18, 32'h01);
        apb_write(32'h10, 32'h01);
        repeat (4) tick();
        apb_write(32'h1C, 32'hFF);
        chk("irq_idle", {31'b0, irq}, 32'h0);
        gpio_in[0] = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (irq) begin
                lat = k;
                break;
            end
        end
        chk("irq_latency", 32'(lat), 32'(SS + 1));
        apb_write(32'h1C, 32'h01);
        chk("w1c_irq", {31'b0, irq}, 32'h0);
        gpio_in[0] = 1'b0;
        repeat (5) tick();
        apb_read(32'h1C);
        chk("fall_no_stat", {31'b0, last_rd[0]}, 32'h0);

        // Pin 1 level-low: W1C cannot clear while the level persists
        apb_write(32'h10, 32'h02);
        repeat (3) tick();
        apb_write(32'h1C, 32'h02);
        tick();
        apb_read(32'h1C);
        chk("lvl_reset", {31'b0, last_rd[1]}, 32'h1);
        chk("lvl_irq", {31'b0, irq}, 32'h1);
        gpio_in[1] = 1'b1;
        repeat (4) tick();
        apb_write(32'h1C, 32'h02);
        chk("lvl_clear_irq", {31'b0, irq}, 32'h0);

        for (int n = 0; n < 500; n++) begin
            op = int'($urandom_range(0, 9));
            a = 32'($urandom_range(0, 9) * 4);
            if ($urandom_range(0, 15) == 0) a = a + 32'($urandom_range(1, 3));
            if (op < 3) gpio_in = W'($urandom);
            else if (op < 6) apb_write(a, $urandom);
            else if (op < 8) apb_read(a);
            else tick();
        end

        // Reset in the access phase of a DATA write
        apb_write(32'h04, 32'hC3);
        apb_write(32'h08, 32'hFF);
        apb_write(32'h0C, 32'hFF);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h5A;
        tick();
        penable = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out", {24'b0, gpio_out}, 32'h0);
        chk("mid_rst_oe", {24'b0, gpio_oe}, 32'h0);
        chk("mid_rst_irq", {31'b0, irq}, 32'h0);
        chk("mid_rst_slverr", {31'b0, pslverr}, 32'h0);
        chk("mid_rst_pready", {31'b0, pready}, 32'h1);
        chk("mid_rst_prdata", prdata, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        apb_read(32'h04);
        chk("lost_write", last_rd, 32'h0);
        apb_write(32'h04, 32'h3C);
        chk("post_rst_out", {24'b0, gpio_out}, 32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
